neuron_mac_seq: RTL and testbench
=================================

Name: neuron_mac_seq

Overview:
- Consumer stage directly downstream of one per-neuron weight BRAM (28 x 16-bit, negedge-registered read) and its matching input-activation buffer.
- On START it sweeps addresses 0..N_INPUTS-1 over both memories and multiplies each weight/activation pair in signed Q8.8.
- It accumulates the products onto a bias, then saturates the sum, applies optional ReLU, and presents one 16-bit neuron output with a valid/ready handshake.

Parameters:
- N_INPUTS, 28, number of weight/activation pairs (BRAM depth).
- ADDR_W, 5, address width into the BRAM and activation buffer.
- DATA_W, 16, weight/activation/bias/output width (signed two's complement).
- FRAC_W, 8, fractional bits of the Q format.
- RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass the signed result.

Ports:
- CLK  in  1  system clock; all block state on posedge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle request to compute one neuron.
- BIAS  in  DATA_W  signed Q8.8 bias, sampled on the START edge.
- BUSY  out  1  high from the START edge until OUT_VALID rises.
- MEM_ADDR  out  ADDR_W  address shared by the weight BRAM and the activation buffer.
- MEM_EN  out  1  read enable to both memories (their WE is tied 0 at top level).
- W_DO  in  DATA_W  weight data from the BRAM.
- X_DO  in  DATA_W  activation data from the buffer (same negedge timing as W_DO).
- OUT_DATA  out  DATA_W  neuron result, Q8.8.
- OUT_VALID  out  1  result valid; held until accepted.
- OUT_READY  in  1  downstream accept.

Behaviour:
- Reset (RST_N=0, async): state IDLE; MEM_EN=0, MEM_ADDR=0, BUSY=0, OUT_VALID=0, OUT_DATA=0; counter, product register and accumulator cleared. Reset mid-sweep abandons the computation; memory contents are untouched.
- States: IDLE -> RUN -> DRAIN -> OUT -> IDLE.
- IDLE:
  - START=1 and OUT_VALID=0 at a posedge (edge 0) -> RUN.
  - On that edge: MEM_ADDR=0, MEM_EN=1, BUSY=1, acc = sign-extended BIAS << FRAC_W.
  - START while BUSY or OUT_VALID=1 is ignored (no queueing).
- RUN:
  - MEM_ADDR increments by 1 each posedge. Address k is driven during cycle k (k = 0..N_INPUTS-1).
  - The memories update DO on the intervening negedge.
  - At posedge k+1 the block registers prod = W_DO * X_DO (signed, 2*DATA_W bits) and sets prod_vld.
  - At posedge k+2, acc += prod.
  - At posedge N_INPUTS: MEM_EN=0, MEM_ADDR returns to 0, state DRAIN.
- DRAIN: last product accumulated at posedge N_INPUTS+1 -> OUT.
- OUT, at posedge N_INPUTS+2:
  - OUT_DATA = sat(acc >>> FRAC_W), OUT_VALID=1, BUSY=0.
  - Latency START edge -> OUT_VALID is N_INPUTS+2 = 30 cycles.
- Arithmetic:
  - acc width ACC_W = 2*DATA_W + clog2(N_INPUTS) + 1 = 38; it never overflows.
  - The shift truncates toward -inf.
  - Saturation: > 0x7FFF -> 0x7FFF; < -0x8000 -> 0x8000.
  - If RELU_EN=1, any negative saturated value -> 0x0000.
- Handshake:
  - OUT_DATA/OUT_VALID stay stable until OUT_VALID&OUT_READY at a posedge.
  - That edge clears OUT_VALID (OUT_DATA retained) and returns to IDLE.
  - A START on the same edge is ignored; the next START is honoured one cycle later.
- MEM_EN is high exactly N_INPUTS consecutive cycles per computation. MEM_ADDR never exceeds N_INPUTS-1 (no wrap).

Decomposition:
- Shared package ann_pkg:
  - constants DATA_W, FRAC_W, N_INPUTS, ADDR_W, ACC_W;
  - state enum {IDLE, RUN, DRAIN, OUT};
  - Q8.8 constants ONE_Q=0x0100, MAX_Q=0x7FFF, MIN_Q=0x8000.
- One natural sub-module: q_sat_relu (combinational: ACC_W input -> shift, saturate, ReLU -> DATA_W output), reused by later layer stages.

Test Plan:
- Weights all 0x0100, activations all 0x0100, BIAS=0, START pulse -> MEM_ADDR 0..27 with MEM_EN high 28 cycles; OUT_VALID at edge 30; OUT_DATA=0x1C00 (28.0).
- Weights 0x0080 (0.5), activations 0x0200 (2.0), BIAS=0xFF00 (-1.0) -> 28*1.0 - 1.0 = 27.0 -> OUT_DATA=0x1B00.
- Weights 0x7FFF, activations 0x7FFF -> positive saturation, OUT_DATA=0x7FFF; weights 0x8000, activations 0x7FFF with RELU_EN=0 -> 0x8000, with RELU_EN=1 -> 0x0000.
- OUT_READY held low 5 cycles after OUT_VALID, START pulsed meanwhile -> OUT_DATA stable, no new sweep (MEM_EN stays 0); accept then START -> normal 30-cycle result.
- RST_N asserted at cycle 10 of a sweep -> MEM_EN, BUSY, OUT_VALID go 0 immediately; after release a new START yields the correct 0x1C00 result.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared constants, state encoding and Q8.8 helpers for the neuron layer stages.
// All arithmetic types are signed two's complement.
package ann_pkg;

  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 8;
  localparam int N_INPUTS = 28;
  localparam int ADDR_W   = 5;
  localparam int PROD_W   = 2 * DATA_W;
  // One guard bit above the worst-case sum of N_INPUTS full-scale products plus bias.
  localparam int ACC_W    = PROD_W + $clog2(N_INPUTS) + 1;

  localparam logic [DATA_W-1:0] ONE_Q = 16'h0100;
  localparam logic [DATA_W-1:0] MAX_Q = 16'h7FFF;
  localparam logic [DATA_W-1:0] MIN_Q = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  typedef logic signed [DATA_W-1:0] q_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Aligns a Q8.8 value to the Q(.16) scale of the accumulated products.
  function automatic acc_t q_to_acc(input q_t v);
    acc_t ext;
    ext = {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    return ext <<< FRAC_W;
  endfunction

  function automatic acc_t prod_to_acc(input prod_t p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/q_sat_relu.sv
// Requantises a wide Q(.16) accumulator to Q8.8: floor shift, saturate, optional ReLU.
// Purely combinational so later layer stages can drop it in after their own accumulators.
module q_sat_relu
  import ann_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DATA_W-1:0] q_o
);

  localparam acc_t MAX_EXT = {{(ACC_W-DATA_W){1'b0}}, MAX_Q};
  localparam acc_t MIN_EXT = {{(ACC_W-DATA_W){1'b1}}, MIN_Q};

  acc_t              shifted;
  logic [DATA_W-1:0] sat_val;

  // Arithmetic shift of a signed value rounds toward minus infinity.
  assign shifted = $signed(acc_i) >>> FRAC_W;

  always_comb begin
    sat_val = shifted[DATA_W-1:0];
    if (shifted > MAX_EXT) begin
      sat_val = MAX_Q;
    end else if (shifted < MIN_EXT) begin
      sat_val = MIN_Q;
    end
  end

  always_comb begin
    q_o = sat_val;
    if (RELU_EN && sat_val[DATA_W-1]) begin
      q_o = '0;
    end
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Single-neuron MAC sequencer: sweeps the weight BRAM and activation buffer, accumulates
// weight*activation onto the bias and hands out one requantised Q8.8 result via valid/ready.
module neuron_mac_seq
  import ann_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] bias_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_en_o,
  input  logic [DATA_W-1:0] w_do_i,
  input  logic [DATA_W-1:0] x_do_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  prod_t             prod_q, prod_d;
  logic              prod_vld_q, prod_vld_d;
  acc_t              acc_q, acc_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] sat_q;
  logic              accept_start;

  // Requests arriving while a result is still pending are dropped, not queued.
  assign accept_start = start_i && !out_valid_q;

  q_sat_relu #(
    .RELU_EN(RELU_EN)
  ) u_sat (
    .acc_i(acc_q),
    .q_o  (sat_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_start) state_d = RUN;
      RUN:     if (addr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     if (out_valid_q && out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    en_d        = en_q;
    busy_d      = busy_q;
    prod_d      = prod_q;
    prod_vld_d  = en_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    // The memories present data on the negedge after the address, so the multiply
    // stage simply trails the read enable by one cycle and the accumulate by two.
    if (en_q) begin
      prod_d = $signed(w_do_i) * $signed(x_do_i);
    end
    if (prod_vld_q) begin
      acc_d = acc_q + prod_to_acc(prod_q);
    end

    case (state_q)
      IDLE: begin
        if (accept_start) begin
          addr_d = '0;
          en_d   = 1'b1;
          busy_d = 1'b1;
          acc_d  = q_to_acc(bias_i);
        end
      end
      RUN: begin
        if (addr_q == LAST_ADDR) begin
          en_d   = 1'b0;
          addr_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          out_data_d  = sat_q;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  assign busy_o      = busy_q;
  assign mem_addr_o  = addr_q;
  assign mem_en_o    = en_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Randomised bench for neuron_mac_seq: two instances (ReLU on/off) share stimulus and are
// compared against an arithmetic reference of the neuron equation.
module tb_neuron_mac_seq;
  import ann_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] bias;
  logic              out_ready;

  logic              busy_r, en_r, valid_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              busy_l, en_l, valid_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] data_l;

  logic [DATA_W-1:0] w_do_r = '0, x_do_r = '0, w_do_l = '0, x_do_l = '0;
  logic [DATA_W-1:0] wmem [N_INPUTS];
  logic [DATA_W-1:0] xmem [N_INPUTS];

  int n_vec = 0;
  int n_err = 0;

  neuron_mac_seq #(.RELU_EN(1'b1)) dut_relu (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bias_i(bias),
    .busy_o(busy_r), .mem_addr_o(addr_r), .mem_en_o(en_r),
    .w_do_i(w_do_r), .x_do_i(x_do_r),
    .out_data_o(data_r), .out_valid_o(valid_r), .out_ready_i(out_ready)
  );

  neuron_mac_seq #(.RELU_EN(1'b0)) dut_lin (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bias_i(bias),
    .busy_o(busy_l), .mem_addr_o(addr_l), .mem_en_o(en_l),
    .w_do_i(w_do_l), .x_do_i(x_do_l),
    .out_data_o(data_l), .out_valid_o(valid_l), .out_ready_i(out_ready)
  );

  // Negedge-registered memory read ports, one pair per instance.
  always @(negedge clk) begin
    if (en_r) begin
      w_do_r <= wmem[addr_r];
      x_do_r <= xmem[addr_r];
    end
    if (en_l) begin
      w_do_l <= wmem[addr_l];
      x_do_l <= xmem[addr_l];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Neuron equation in plain integer arithmetic with floor division by 2^FRAC_W.
  function automatic logic [DATA_W-1:0] ref_neuron(input logic [DATA_W-1:0] b, input bit relu);
    longint s, q;
    s = longint'($signed(b)) * 256;
    for (int i = 0; i < N_INPUTS; i++) begin
      s += longint'($signed(wmem[i])) * longint'($signed(xmem[i]));
    end
    q = (s - (((s % 256) + 256) % 256)) / 256;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    if (relu && q < 0) q = 0;
    return q[DATA_W-1:0];
  endfunction

  task automatic fill_const(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] x);
    for (int i = 0; i < N_INPUTS; i++) begin
      wmem[i] = w;
      xmem[i] = x;
    end
  endtask

  task automatic fill_rand(input int mode);
    for (int i = 0; i < N_INPUTS; i++) begin
      case (mode)
        0: begin
          wmem[i] = 16'($urandom_range(0, 1023) - 512);
          xmem[i] = 16'($urandom_range(0, 1023) - 512);
        end
        1: begin
          wmem[i] = 16'($urandom);
          xmem[i] = 16'($urandom);
        end
        default: begin
          wmem[i] = 16'($urandom_range(0, 255));
          xmem[i] = 16'($urandom_range(0, 4095) - 2048);
        end
      endcase
    end
  endtask

  // One full computation: start, sweep, result, optional backpressure, accept.
  task automatic run_txn(input string name, input logic [DATA_W-1:0] b, input int hold);
    logic [DATA_W-1:0] exp_r, exp_l;
    int j, en_cnt;
    bit seen;
    exp_r  = ref_neuron(b, 1'b1);
    exp_l  = ref_neuron(b, 1'b0);
    start  = 1'b1;
    bias   = b;
    tick();
    start  = 1'b0;
    bias   = 16'($urandom);
    en_cnt = 0;
    seen   = 1'b0;
    for (j = 0; j < 60; j++) begin
      if (valid_r) begin
        seen = 1'b1;
        break;
      end
      chk({name, " busy"}, busy_r, 1);
      if (en_r) begin
        chk({name, " addr"}, addr_r, j);
        en_cnt++;
      end else begin
        chk({name, " addr_idle"}, addr_r, 0);
      end
      start = (j == 5);
      tick();
    end
    start = 1'b0;
    chk({name, " valid_seen"}, seen, 1);
    chk({name, " latency"}, j, N_INPUTS + 2);
    chk({name, " en_cycles"}, en_cnt, N_INPUTS);
    chk({name, " data_relu"}, data_r, exp_r);
    chk({name, " valid_lin"}, valid_l, 1);
    chk({name, " data_lin"}, data_l, exp_l);
    chk({name, " busy_done"}, busy_r, 0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = (h == 1);
      tick();
      chk({name, " hold_valid"}, valid_r, 1);
      chk({name, " hold_data"}, data_r, exp_r);
      chk({name, " hold_en"}, en_r, 0);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk({name, " accept_valid"}, valid_r, 0);
    chk({name, " accept_valid_lin"}, valid_l, 0);
    chk({name, " accept_data"}, data_r, exp_r);
    chk({name, " accept_en"}, en_r, 0);
    $display("txn %s bias=%h relu=%h lin=%h latency=%0d hold=%0d",
             name, b, data_r, data_l, j, hold);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    bias      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset en", en_r, 0);
    chk("reset busy", busy_r, 0);
    chk("reset valid", valid_r, 0);
    chk("reset addr", addr_r, 0);
    chk("reset data", data_r, 0);
    rst_n = 1'b1;
    tick();

    fill_const(16'h0100, 16'h0100);
    run_txn("unity", 16'h0000, 0);
    chk("unity literal", data_r, 16'h1C00);

    fill_const(16'h0080, 16'h0200);
    run_txn("half_x_two", 16'hFF00, 1);
    chk("half_x_two literal", data_r, 16'h1B00);

    fill_const(16'h7FFF, 16'h7FFF);
    run_txn("pos_sat", 16'h0000, 0);
    chk("pos_sat literal", data_r, 16'h7FFF);

    fill_const(16'h8000, 16'h7FFF);
    run_txn("neg_sat", 16'h0000, 2);
    chk("neg_sat relu literal", data_r, 16'h0000);
    chk("neg_sat lin literal", data_l, 16'h8000);

    fill_const(16'h0100, 16'h0100);
    run_txn("backpressure", 16'h0000, 5);

    for (int t = 0; t < 12; t++) begin
      fill_rand(t % 3);
      run_txn($sformatf("rand%0d", t), 16'($urandom), $urandom_range(0, 5));
    end

    // Abandon a sweep with an asynchronous reset at cycle 10.
    fill_const(16'h0100, 16'h0100);
    start = 1'b1;
    bias  = 16'h0300;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("pre_reset en", en_r, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset en", en_r, 0);
    chk("midreset busy", busy_r, 0);
    chk("midreset valid", valid_r, 0);
    chk("midreset addr", addr_r, 0);
    chk("midreset data", data_r, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_txn("after_reset", 16'h0000, 1);
    chk("after_reset literal", data_r, 16'h1C00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
